// File: rtl/braid_mix_sequencer.sv
// Issues the actuation stream for a LANES x STAGES mixer braid: LOAD all lanes, MIX each stage from STAGES-1 down to 0
// with a fixed dwell after each stage, then DRAIN. Commands use valid/ready, and the payload holds until it is accepted.
module braid_mix_sequencer #(
  parameter int LANES      = 4,
  parameter int STAGES     = 32,
  parameter int MIX_CYCLES = 16,
  parameter int STW        = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [1:0]               cmd_op_o,
  output logic [STW-1:0]           cmd_stage_o,
  output logic [$clog2(LANES)-1:0] cmd_lane_o,
  output logic [$clog2(LANES)-1:0] cmd_partner_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic [STW-1:0]           cur_stage_o
);

  localparam int LW = $clog2(LANES);
  localparam int WW = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
  localparam logic [LW-1:0]  LAST_LANE  = LW'(LANES - 1);
  localparam logic [STW-1:0] LOAD_STAGE = STW'(STAGES);
  localparam logic [STW-1:0] TOP_STAGE  = STW'(STAGES - 1);
  localparam logic [WW-1:0]  DWELL_INIT = WW'(MIX_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIX, S_WAIT, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic           vld_q, vld_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [STW-1:0] stage_q, stage_d;
  logic [WW-1:0]  dwell_q, dwell_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;
  logic           xfer;

  assign xfer = vld_q && cmd_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      vld_q     <= 1'b0;
      lane_q    <= '0;
      stage_q   <= '0;
      dwell_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      lane_q    <= lane_d;
      stage_q   <= stage_d;
      dwell_q   <= dwell_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    lane_d    = lane_q;
    stage_d   = stage_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q != S_IDLE && abort_i) begin
      state_d   = S_IDLE;
      vld_d     = 1'b0;
      lane_d    = '0;
      stage_d   = '0;
      dwell_d   = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) state_d = S_LOAD;
        end
        S_WAIT: begin
          // Zero is tested before decrementing, so stage 0 leads to DRAIN without wrapping.
          if (dwell_q == '0) begin
            if (stage_q == '0) begin
              state_d = S_DRAIN;
            end else begin
              stage_d = stage_q - STW'(1);
              state_d = S_MIX;
            end
          end else begin
            dwell_d = dwell_q - WW'(1);
          end
        end
        S_LOAD, S_MIX, S_DRAIN: begin
          // valid is low only on the entry cycle of a command state.
          if (!vld_q) begin
            vld_d = 1'b1;
          end else if (xfer) begin
            lane_d = lane_q + LW'(1);
            if (lane_q == LAST_LANE) begin
              vld_d = 1'b0;
              case (state_q)
                S_LOAD: begin
                  state_d = S_MIX;
                  stage_d = TOP_STAGE;
                end
                S_MIX: begin
                  state_d = S_WAIT;
                  dwell_d = DWELL_INIT;
                end
                default: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_op_o      = 2'd0;
    cmd_stage_o   = '0;
    cmd_lane_o    = '0;
    cmd_partner_o = '0;
    cur_stage_o   = '0;
    case (state_q)
      S_LOAD:        cur_stage_o = LOAD_STAGE;
      S_MIX, S_WAIT: cur_stage_o = stage_q;
      default:       cur_stage_o = '0;
    endcase
    if (vld_q) begin
      cmd_lane_o    = lane_q;
      cmd_partner_o = lane_q;
      case (state_q)
        S_LOAD: cmd_stage_o = LOAD_STAGE;
        S_MIX: begin
          cmd_op_o      = 2'd1;
          cmd_stage_o   = stage_q;
          cmd_partner_o = lane_q + LW'(1);
        end
        default: cmd_op_o = 2'd2;
      endcase
    end
  end

  assign cmd_valid_o = vld_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_braid_mix_sequencer.sv
// Scoreboard bench: default-parameter instance plus a LANES=2/STAGES=1/MIX_CYCLES=1 instance.
module tb_braid_mix_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, cmd_ready;
  logic       cmd_valid, busy, done, aborted;
  logic [1:0] cmd_op, cmd_lane, cmd_partner;
  logic [5:0] cmd_stage, cur_stage;

  logic       e_start, e_abort, e_ready;
  logic       e_valid, e_busy, e_done, e_aborted;
  logic [1:0] e_op, e_stage, e_cur;
  logic [0:0] e_lane, e_partner;

  braid_mix_sequencer u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_stage_o(cmd_stage), .cmd_lane_o(cmd_lane), .cmd_partner_o(cmd_partner),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .cur_stage_o(cur_stage)
  );

  braid_mix_sequencer #(.LANES(2), .STAGES(1), .MIX_CYCLES(1), .STW(2)) u_edge (
    .clk_i(clk), .rst_i(rst), .start_i(e_start), .abort_i(e_abort),
    .cmd_valid_o(e_valid), .cmd_ready_i(e_ready), .cmd_op_o(e_op),
    .cmd_stage_o(e_stage), .cmd_lane_o(e_lane), .cmd_partner_o(e_partner),
    .busy_o(e_busy), .done_o(e_done), .aborted_o(e_aborted), .cur_stage_o(e_cur)
  );

  int checks = 0, failures = 0;
  int xfer_cnt = 0, busy_cyc = 0, idle_cyc = 0, done_cnt = 0, abrt_cnt = 0;
  int e_xfer = 0, e_idle = 0, e_busy_cyc = 0, e_done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  e_exp_q[$];
  logic hold_pend = 1'b0, abort_prev = 1'b0;
  int x0, d0, a0, b0, i0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Expected entry: {op, stage, lane, partner, cur_stage}; cur_stage tracks the command's stage.
  function automatic void push_cmd(input int op, input int st, input int ln, input int pt);
    exp_q.push_back({op[1:0], st[5:0], ln[1:0], pt[1:0], st[5:0]});
  endfunction

  task automatic push_run(input int n);
    int k = 0;
    for (int j = 0; j < 4; j++) begin
      if (k < n) push_cmd(0, 32, j, j);
      k++;
    end
    for (int s = 31; s >= 0; s--) begin
      for (int j = 0; j < 4; j++) begin
        if (k < n) push_cmd(1, s, j, (j + 1) % 4);
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (k < n) push_cmd(2, 0, j, j);
      k++;
    end
  endtask

  function automatic int cnt_sel(input int which);
    case (which)
      0: return xfer_cnt;
      1: return done_cnt;
      default: return e_done_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input int bound, input string nm);
    int n = 0;
    while (cnt_sel(which) < target && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    if (cnt_sel(which) < target) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles, count %0d, expected %0d", nm, n, cnt_sel(which), target);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic snap();
    x0 = xfer_cnt; d0 = done_cnt; a0 = abrt_cnt; b0 = busy_cyc; i0 = idle_cyc;
  endtask

  // Main monitor: every presented command must match the queue head, stalled or not.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (busy && !cmd_valid) idle_cyc++;
        if (done) done_cnt++;
        if (aborted) abrt_cnt++;
        if (done || aborted) chk("pulse_excl", {30'd0, done & aborted, cmd_valid}, 32'd0);
        if (hold_pend && !abort_prev) chk("hold_valid", {31'd0, cmd_valid}, 32'd1);
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_cmd: got op=%0d stage=%0d lane=%0d, expected no command", cmd_op, cmd_stage, cmd_lane);
          end else begin
            chk("cmd_payload", {14'd0, cmd_op, cmd_stage, cmd_lane, cmd_partner, cur_stage}, {14'd0, exp_q[0]});
            if (cmd_ready) void'(exp_q.pop_front());
          end
          if (cmd_ready) xfer_cnt++;
        end
        hold_pend  = cmd_valid && !cmd_ready;
        abort_prev = abort;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (e_busy) e_busy_cyc++;
        if (e_busy && !e_valid) e_idle++;
        if (e_done) e_done_cnt++;
        if (e_valid) begin
          if (e_exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL edge_extra_cmd: got op=%0d lane=%0d, expected no command", e_op, e_lane);
          end else begin
            chk("edge_payload", {26'd0, e_op, e_stage, e_lane, e_partner}, {26'd0, e_exp_q[0]});
            if (e_ready) void'(e_exp_q.pop_front());
          end
          if (e_ready) e_xfer++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
    e_start = 1'b0; e_abort = 1'b0; e_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, aborted}, 32'd0);
    chk("rst_payload", {14'd0, cmd_op, cmd_stage, cmd_lane, cmd_partner, cur_stage}, 32'd0);
    chk("rst_edge", {29'd0, e_valid, e_busy, e_done}, 32'd0);

    // start together with abort in IDLE: nothing happens
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk); #1;
    chk("idle_abort_wins", {30'd0, busy, aborted}, 32'd0);

    // Edge parameters
    e_exp_q.push_back({2'd0, 2'd1, 1'b0, 1'b0});
    e_exp_q.push_back({2'd0, 2'd1, 1'b1, 1'b1});
    e_exp_q.push_back({2'd1, 2'd0, 1'b0, 1'b1});
    e_exp_q.push_back({2'd1, 2'd0, 1'b1, 1'b0});
    e_exp_q.push_back({2'd2, 2'd0, 1'b0, 1'b0});
    e_exp_q.push_back({2'd2, 2'd0, 1'b1, 1'b1});
    @(posedge clk); #1 e_start = 1'b1;
    @(posedge clk); #1 e_start = 1'b0;
    wait_cnt(2, 1, 200, "edge_done_wait");
    chk("edge_busy_after", {31'd0, e_busy}, 32'd0);
    chk("edge_xfers", e_xfer, 6);
    chk("edge_idle_cycles", e_idle, 4);
    chk("edge_busy_cycles", e_busy_cyc, 10);
    chk("edge_queue_empty", e_exp_q.size(), 0);

    // Nominal run, ready held high
    snap();
    push_run(136);
    cmd_ready = 1'b1;
    pulse_start();
    wait_cnt(1, d0 + 1, 2000, "nom_done_wait");
    chk("nom_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk); #1;
    chk("nom_xfers", xfer_cnt - x0, 136);
    chk("nom_done_pulses", done_cnt - d0, 1);
    chk("nom_busy_cycles", busy_cyc - b0, 682);
    chk("nom_idle_cycles", idle_cyc - i0, 546);
    chk("nom_queue_empty", exp_q.size(), 0);

    // Random backpressure, with start pulses while busy
    snap();
    push_run(136);
    @(posedge clk); #1 start = 1'b1; cmd_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      start = (i == 40 || i == 41 || i == 300) ? 1'b1 : 1'b0;
      cmd_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      failures++;
      $display("FAIL bp_done_wait: timeout, done pulses 0, expected 1");
    end
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("bp_xfers", xfer_cnt - x0, 136);
    chk("bp_done_pulses", done_cnt - d0, 1);
    chk("bp_idle_cycles", idle_cyc - i0, 546);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Abort during WAIT after stage 20
    snap();
    push_run(52);
    pulse_start();
    wait_cnt(0, x0 + 52, 2000, "abw_xfer_wait");
    @(posedge clk);
    @(negedge clk); #1;
    chk("abw_in_wait", {25'd0, busy, cmd_valid, cur_stage}, {25'd0, 1'b1, 1'b0, 6'd20});
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    chk("abw_state", {29'd0, aborted, busy, cmd_valid}, {29'd0, 3'b100});
    @(negedge clk); #1;
    chk("abw_pulse_width", {31'd0, aborted}, 32'd0);
    repeat (20) @(negedge clk); #1;
    chk("abw_xfers", xfer_cnt - x0, 52);
    chk("abw_no_done", done_cnt - d0, 0);
    chk("abw_aborts", abrt_cnt - a0, 1);
    chk("abw_queue_empty", exp_q.size(), 0);

    // Full run after the abort
    snap();
    push_run(136);
    pulse_start();
    wait_cnt(1, d0 + 1, 2000, "rerun_done_wait");
    repeat (2) @(negedge clk); #1;
    chk("rerun_xfers", xfer_cnt - x0, 136);
    chk("rerun_queue_empty", exp_q.size(), 0);

    // Abort while stalled on MIX stage 5 lane 2
    snap();
    push_run(111);
    pulse_start();
    wait_cnt(0, x0 + 110, 2000, "abm_xfer_wait");
    @(posedge clk); #1 cmd_ready = 1'b0; abort = 1'b1;
    @(negedge clk); #1;
    chk("abm_stall_cmd", {19'd0, cmd_valid, cmd_op, cmd_stage, cmd_lane, cmd_partner},
        {19'd0, 1'b1, 2'd1, 6'd5, 2'd2, 2'd3});
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    chk("abm_state", {29'd0, aborted, busy, cmd_valid}, {29'd0, 3'b100});
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk); #1;
    chk("abm_xfers", xfer_cnt - x0, 110);
    chk("abm_no_done", done_cnt - d0, 0);
    chk("abm_queue_left", exp_q.size(), 1);
    exp_q.delete();

    // rst in the middle of DRAIN
    snap();
    push_run(134);
    pulse_start();
    wait_cnt(0, x0 + 134, 2000, "rst_xfer_wait");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_flags", {28'd0, cmd_valid, busy, done, aborted}, 32'd0);
    chk("mid_rst_payload", {14'd0, cmd_op, cmd_stage, cmd_lane, cmd_partner, cur_stage}, 32'd0);
    repeat (10) @(negedge clk); #1;
    chk("mid_rst_no_pulses", {(done_cnt - d0), (abrt_cnt - a0)}, 64'd0);
    chk("mid_rst_xfers", xfer_cnt - x0, 134);
    chk("mid_rst_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/braid_mix_sequencer.md
Name: braid_mix_sequencer

Overview:
- Control-side driver for a LANES x STAGES mixer braid fabric.
- The braid netlist is the fluidic datapath. This block issues the actuation command stream that loads its inputs, fires each mixer stage from the input end to the output end, and then drains the outputs.
- Sits between the chip-level protocol controller (start/abort) and the valve/actuator command interface (valid/ready).

Parameters:
- LANES, 4, number of braid lanes; must be a power of two, >= 2.
- STAGES, 32, number of mixer stages; >= 1.
- MIX_CYCLES, 16, dwell cycles after a stage's last MIX is accepted; >= 1.
- STW, 6, width of cmd_stage; must satisfy 2^STW > STAGES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the current run.
- cmd_valid  out  1  command present.
- cmd_ready  in  1  actuator accepts the command.
- cmd_op  out  2  0=LOAD, 1=MIX, 2=DRAIN, 3=reserved.
- cmd_stage  out  STW  stage index; LOAD uses STAGES.
- cmd_lane  out  log2(LANES)  destination lane j.
- cmd_partner  out  log2(LANES)  second source lane, (j+1) mod LANES; equals cmd_lane for LOAD/DRAIN.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- cur_stage  out  STW  stage currently being mixed; STAGES during LOAD, 0 during DRAIN.

Behaviour:
- Reset: state=IDLE. cmd_valid, busy, done and aborted are 0. All payload outputs and counters are 0. cur_stage=0.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> MIX after LANES accepted commands.
  - MIX -> WAIT after LANES accepted commands.
  - WAIT -> MIX (stage-1) when dwell expires and stage>0.
  - WAIT -> DRAIN when dwell expires and stage==0.
  - DRAIN -> IDLE after LANES accepted commands, with a done pulse.
- LOAD: op=0, stage=STAGES, lanes 0..LANES-1 in ascending order.
- MIX: stage s runs from STAGES-1 down to 0. Commands are op=1, stage=s, lane j ascending, partner=(j+1) mod LANES.
- WAIT: cmd_valid=0. A counter loads MIX_CYCLES-1 on the cycle the stage's last MIX is accepted, then decrements. WAIT exits on the cycle the counter reads 0, so WAIT lasts exactly MIX_CYCLES cycles.
- DRAIN: op=2, stage=0, lanes ascending.
- Handshake:
  - A transfer occurs on a cycle with cmd_valid && cmd_ready.
  - Once asserted, cmd_valid and the payload hold stable until the transfer.
  - After a transfer, the next command (same state) is presented on the following cycle. Back-to-back transfers sustain 1 per cycle.
  - The first command of a state is presented the cycle after the state is entered.
  - cmd_ready while cmd_valid=0 is ignored.
- Command count per run: LANES*(STAGES+2). With defaults this is 136.
- Minimum run length with cmd_ready tied high: 136 transfer cycles + STAGES*MIX_CYCLES wait cycles + one entry cycle per command state.
- start while busy is ignored. start and abort together in IDLE: abort wins, no run begins, no aborted pulse.
- Abort (any non-IDLE state):
  - Next cycle: state=IDLE, cmd_valid=0, busy=0, and aborted=1 for one cycle.
  - This is the only case in which cmd_valid may drop without a transfer.
  - A transfer on the abort cycle itself counts as accepted.
  - done is never pulsed after abort.
- rst mid-run: return to the reset values the next cycle. No done or aborted pulse.
- done and aborted are mutually exclusive and never coincide with cmd_valid.
- Counters: the stage counter decrements from STAGES-1 with no wrap below 0; the 0 check precedes the decrement. The lane counter wraps LANES-1 -> 0 on the last transfer of each state.

Test Plan:
- Nominal run, cmd_ready=1 constantly, defaults:
  - Exactly 136 transfers.
  - Sequence: 4 LOAD at stage 32, then MIX at stage 31 with (lane, partner) pairs (0,1), (1,2), (2,3), (3,0), ..., MIX at stage 0, then 4 DRAIN.
  - 16 idle cycles after each stage.
  - A single done pulse, then busy=0.
- Backpressure: toggle cmd_ready with a random ~50% pattern -> same 136-command sequence; payload is stable every stalled cycle; no duplicate or dropped commands.
- Abort during WAIT after stage 20's MIXes -> next cycle IDLE, aborted=1 for 1 cycle, cmd_valid=0; no done; a subsequent start yields a full 136-command run.
- Abort while cmd_valid=1, cmd_ready=0 in MIX (stage 5, lane 2) -> cmd_valid drops next cycle, aborted pulses, no further transfers.
- Edge parameters LANES=2, STAGES=1, MIX_CYCLES=1 -> sequence LOAD s1 l0, LOAD s1 l1, MIX s0 (0,1), MIX s0 (1,0), 1 WAIT cycle, DRAIN l0, DRAIN l1, done.
- rst asserted mid-DRAIN; start pulsed while busy -> reset values next cycle, no pulses; the start while busy has no effect on the command count (still 136).
